// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The producer/consumer side uses the master modport, the adder uses slave.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             sum_msb;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, sum_msb
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, sum_msb
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor.
// The carry chain is cut into STAGES slices of CHUNK bits; slice k adds its
// chunk with the carry registered by slice k-1. Unconsumed operand chunks and
// finished sum chunks travel along with each entry. A single global advance
// enable stalls the whole pipe (bubbles included) under backpressure.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_adder: STAGES must be 1..WIDTH and divide WIDTH");
        end
    endgenerate

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];

    logic             v_in  [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];

    logic [CHUNK:0]   part_d [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic             c_d    [STAGES];

    logic adv;

    // Whole pipe moves only when the output slot is free or being drained.
    assign adv          = !vld_q[LAST] || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.sum_msb   = s_q[LAST][WIDTH-1];
    assign bus.overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                           (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

    // Slice inputs: slice 0 takes the effective operands, later slices the previous register.
    always_comb begin
        v_in[0] = bus.in_valid;
        a_in[0] = bus.a;
        b_in[0] = bus.sub ? ~bus.b : bus.b;
        s_in[0] = '0;
        c_in[0] = bus.cin ^ bus.sub;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = vld_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    // Per-slice CHUNK-bit add; the result chunk is spliced into the travelling sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part_d[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_in[k]};
            s_d[k]                     = s_in[k];
            s_d[k][k*CHUNK +: CHUNK]   = part_d[k][CHUNK-1:0];
            c_d[k]                     = part_d[k][CHUNK];
        end
    end

    // Stage registers: valid bits follow the advance enable, data loads only for valid entries
    // so the output holds its last result across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end
endmodule
